// File: rtl/btb_assoc.sv
// ---------------------------------------------------------------------------
// btb_assoc -- set-associative branch target buffer for the fetch predictor.
//
// Looked up every cycle with the fetch-group PC (1-cycle latency), written by
// the branch unit on resolution. Entries carry tag, target, branch type and
// the slot bit of the branch inside its fetch group. Replacement is tree-PLRU.
//
// Ports
//   clk              clock, all state on posedge
//   rst              synchronous active-high reset
//   pc               lookup PC, sampled every cycle
//   hit              lookup result for the PC sampled at the previous edge
//   br_target        predicted target (0 on miss)
//   br_type          predicted branch type (0 on miss)
//   pc_2             stored slot bit of the hitting entry (0 on miss)
//   update           write request from the branch unit
//   update_pc        PC of the resolved branch
//   update_br_type   resolved type; 0 invalidates the matching entry
//   update_br_target resolved target
//   flush            invalidate every entry
// ---------------------------------------------------------------------------
module btb_assoc #(
    parameter int PC_W     = 30,
    parameter int INDEX_W  = 8,
    parameter int WAYS     = 2,
    parameter int TARGET_W = 30,
    parameter int TYPE_W   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PC_W-1:0]     pc,
    output logic                hit,
    output logic [TARGET_W-1:0] br_target,
    output logic [TYPE_W-1:0]   br_type,
    output logic                pc_2,
    input  logic                update,
    input  logic [PC_W-1:0]     update_pc,
    input  logic [TYPE_W-1:0]   update_br_type,
    input  logic [TARGET_W-1:0] update_br_target,
    input  logic                flush
);
    localparam int SETS    = 1 << INDEX_W;
    localparam int TAG_W   = PC_W - 1 - INDEX_W;
    // Entry layout, MSB to LSB: {tag, target, type, slot}
    localparam int ENTRY_W = TAG_W + TARGET_W + TYPE_W + 1;

    generate
        if (WAYS != 1 && WAYS != 2 && WAYS != 4) begin : g_bad_ways
            $error("btb_assoc: WAYS must be 1, 2 or 4");
        end
    endgenerate

    function automatic logic [TAG_W-1:0] ent_tag(input logic [ENTRY_W-1:0] e);
        return e[ENTRY_W-1 -: TAG_W];
    endfunction

    // Tree-PLRU kept in 3 bits for every associativity: bit0 is the root
    // (0 = victim in ways 0/1), bit1 picks within ways 0/1, bit2 within 2/3.
    // A 2-way set only uses bit0; a 1-way set uses none.
    function automatic logic [1:0] plru_victim(input logic [2:0] b);
        logic [1:0] v;
        if (WAYS == 4) begin
            v = b[0] ? {1'b1, b[2]} : {1'b0, b[1]};
        end else if (WAYS == 2) begin
            v = {1'b0, b[0]};
        end else begin
            v = 2'd0;
        end
        return v;
    endfunction

    // Point every tree node on the path to way w away from it.
    function automatic logic [2:0] plru_touch(input logic [2:0] b, input logic [1:0] w);
        logic [2:0] r;
        r = b;
        if (WAYS == 4) begin
            r[0] = ~w[1];
            if (w[1]) begin
                r[2] = ~w[0];
            end else begin
                r[1] = ~w[0];
            end
        end else if (WAYS == 2) begin
            r[0] = ~w[0];
        end else begin
            r = b;
        end
        return r;
    endfunction

    logic [ENTRY_W-1:0] ram_q [WAYS][SETS];
    logic [ENTRY_W-1:0] rd_q [WAYS];
    logic [WAYS-1:0]    valid_q [SETS];
    logic [2:0]         plru_q [SETS];

    logic [WAYS-1:0]    lk_valid_q;
    logic [TAG_W-1:0]   lk_tag_q;
    logic [INDEX_W-1:0] lk_idx_q;

    logic [INDEX_W-1:0] pc_idx_s, upd_idx_s;
    logic [TAG_W-1:0]   pc_tag_s, upd_tag_s;
    logic [ENTRY_W-1:0] upd_entry_s, lk_sel_s;
    logic [WAYS-1:0]    upd_hit_vec_s, upd_we_s, upd_clr_s, lk_hit_vec_s;
    logic               upd_hit_s, upd_free_s, upd_go_s, upd_alloc_s, lk_hit_s;
    logic [1:0]         upd_hit_way_s, upd_free_way_s, upd_tgt_way_s, lk_way_s;
    // The lookup slot bit never selects an entry; the stored slot is reported.
    logic               unused_pc_slot_s;

    assign unused_pc_slot_s = pc[0];
    assign pc_idx_s    = pc[INDEX_W:1];
    assign pc_tag_s    = pc[PC_W-1:INDEX_W+1];
    assign upd_idx_s   = update_pc[INDEX_W:1];
    assign upd_tag_s   = update_pc[PC_W-1:INDEX_W+1];
    assign upd_entry_s = {upd_tag_s, update_br_target, update_br_type, update_pc[0]};

    // Update decode: tag match, lowest free way, victim choice and write enables.
    always_comb begin
        upd_hit_vec_s  = '0;
        upd_hit_way_s  = 2'd0;
        upd_free_way_s = 2'd0;
        upd_free_s     = 1'b0;
        upd_we_s       = '0;
        upd_clr_s      = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            upd_hit_vec_s[w] = valid_q[upd_idx_s][w] &&
                               (ent_tag(ram_q[w][upd_idx_s]) == upd_tag_s);
            upd_hit_way_s    = upd_hit_vec_s[w] ? 2'(w) : upd_hit_way_s;
            upd_free_way_s   = !valid_q[upd_idx_s][w] ? 2'(w) : upd_free_way_s;
            upd_free_s       = upd_free_s | !valid_q[upd_idx_s][w];
        end
        upd_hit_s = |upd_hit_vec_s;
        if (upd_hit_s) begin
            upd_tgt_way_s = upd_hit_way_s;
        end else if (upd_free_s) begin
            upd_tgt_way_s = upd_free_way_s;
        end else begin
            upd_tgt_way_s = plru_victim(plru_q[upd_idx_s]);
        end
        // Reset and flush both drop a concurrent update.
        upd_go_s    = update && !rst && !flush;
        upd_alloc_s = upd_go_s && (update_br_type != '0);
        for (int w = 0; w < WAYS; w++) begin
            upd_we_s[w]  = upd_alloc_s && (upd_tgt_way_s == 2'(w));
            upd_clr_s[w] = upd_go_s && (update_br_type == '0) && upd_hit_s &&
                           (upd_hit_way_s == 2'(w));
        end
    end

    // Entry RAM per way: one write port, one registered read port (read-old).
    always_ff @(posedge clk) begin
        for (int w = 0; w < WAYS; w++) begin
            if (upd_we_s[w]) begin
                ram_q[w][upd_idx_s] <= upd_entry_s;
            end
            rd_q[w] <= ram_q[w][pc_idx_s];
        end
    end

    // Lookup pipeline: valid snapshot taken with the RAM read, masked by flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            lk_valid_q <= '0;
            lk_tag_q   <= '0;
            lk_idx_q   <= '0;
        end else begin
            lk_valid_q <= flush ? '0 : valid_q[pc_idx_s];
            lk_tag_q   <= pc_tag_s;
            lk_idx_q   <= pc_idx_s;
        end
    end

    // Valid bits: reset/flush clear every set at once, else update set/clear.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
            end
        end else begin
            for (int w = 0; w < WAYS; w++) begin
                if (upd_we_s[w]) begin
                    valid_q[upd_idx_s][w] <= 1'b1;
                end else if (upd_clr_s[w]) begin
                    valid_q[upd_idx_s][w] <= 1'b0;
                end
            end
        end
    end

    // PLRU: lookup-hit touch first so an update touch on the same set overrides it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                plru_q[s] <= 3'd0;
            end
        end else begin
            if (lk_hit_s) begin
                plru_q[lk_idx_q] <= plru_touch(plru_q[lk_idx_q], lk_way_s);
            end
            if (upd_alloc_s) begin
                plru_q[upd_idx_s] <= plru_touch(plru_q[upd_idx_s], upd_tgt_way_s);
            end
        end
    end

    // Hit resolution on the registered read data; lowest hitting way wins.
    always_comb begin
        lk_hit_vec_s = '0;
        lk_way_s     = 2'd0;
        lk_sel_s     = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            lk_hit_vec_s[w] = lk_valid_q[w] && (ent_tag(rd_q[w]) == lk_tag_q);
            lk_way_s        = lk_hit_vec_s[w] ? 2'(w) : lk_way_s;
            lk_sel_s        = lk_hit_vec_s[w] ? rd_q[w] : lk_sel_s;
        end
        lk_hit_s  = |lk_hit_vec_s;
        hit       = lk_hit_s;
        br_target = lk_sel_s[TARGET_W+TYPE_W -: TARGET_W];
        br_type   = lk_sel_s[TYPE_W:1];
        pc_2      = lk_sel_s[0];
    end
endmodule

// File: tb/tb_btb_assoc.sv
module tb_btb_assoc;
    localparam logic [29:0] IDLE = 30'h3FFF_FE00;   // set 0, tag never written

    logic        clk = 1'b0;
    logic        rst, hit, pc_2, update, flush;
    logic [29:0] pc, br_target, update_pc, update_br_target;
    logic [1:0]  br_type, update_br_type;

    btb_assoc #(.PC_W(30), .INDEX_W(8), .WAYS(2), .TARGET_W(30), .TYPE_W(2)) dut (
        .clk(clk), .rst(rst), .pc(pc), .hit(hit), .br_target(br_target),
        .br_type(br_type), .pc_2(pc_2), .update(update), .update_pc(update_pc),
        .update_br_type(update_br_type), .update_br_target(update_br_target),
        .flush(flush)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: per set, two ways of {valid, tag, data}; replacement is "least
    // recently touched" by timestamp, which for two ways is what PLRU picks.
    bit          m_valid [256][2];
    int unsigned m_tag   [256][2];
    int unsigned m_tgt   [256][2];
    int unsigned m_type  [256][2];
    int unsigned m_slot  [256][2];
    longint      m_stamp [256][2];
    longint      stamp_ctr = 0;

    logic        exp_hit = 1'b0, exp_pc2 = 1'b0;
    logic [29:0] exp_tgt = 30'h0;
    logic [1:0]  exp_type = 2'd0;
    bit          started = 1'b0;
    bit          pend_hit = 1'b0;
    int          pend_set = 0, pend_way = 0;

    always @(posedge clk) begin
        int uidx, lidx, uh, uf, uw, lh;
        int unsigned utag, ltag;
        if (rst) begin
            for (int s = 0; s < 256; s++) begin
                for (int w = 0; w < 2; w++) begin
                    m_valid[s][w] = 1'b0;
                    m_stamp[s][w] = 0;
                end
            end
            exp_hit = 1'b0; exp_tgt = 30'h0; exp_type = 2'd0; exp_pc2 = 1'b0;
            pend_hit = 1'b0;
            started = 1'b1;
        end else begin
            // All decisions use the state before this edge.
            uidx = int'(update_pc[8:1]);
            utag = int'(update_pc[29:9]);
            uh = -1; uf = -1;
            for (int w = 1; w >= 0; w--) begin
                if (m_valid[uidx][w] && m_tag[uidx][w] == utag) uh = w;
                if (!m_valid[uidx][w]) uf = w;
            end
            if (uh >= 0) uw = uh;
            else if (uf >= 0) uw = uf;
            else uw = (m_stamp[uidx][0] <= m_stamp[uidx][1]) ? 0 : 1;

            lidx = int'(pc[8:1]);
            ltag = int'(pc[29:9]);
            lh = -1;
            for (int w = 1; w >= 0; w--) begin
                if (m_valid[lidx][w] && m_tag[lidx][w] == ltag) lh = w;
            end
            if (flush) lh = -1;

            if (pend_hit) begin
                stamp_ctr++;
                m_stamp[pend_set][pend_way] = stamp_ctr;
            end

            if (lh >= 0) begin
                exp_hit  = 1'b1;
                exp_tgt  = 30'(m_tgt[lidx][lh]);
                exp_type = 2'(m_type[lidx][lh]);
                exp_pc2  = m_slot[lidx][lh][0];
            end else begin
                exp_hit = 1'b0; exp_tgt = 30'h0; exp_type = 2'd0; exp_pc2 = 1'b0;
            end
            pend_hit = (lh >= 0);
            pend_set = lidx;
            pend_way = lh;

            if (flush) begin
                for (int s = 0; s < 256; s++) begin
                    m_valid[s][0] = 1'b0;
                    m_valid[s][1] = 1'b0;
                end
            end else if (update) begin
                if (update_br_type != 2'd0) begin
                    m_valid[uidx][uw] = 1'b1;
                    m_tag[uidx][uw]   = utag;
                    m_tgt[uidx][uw]   = int'(update_br_target);
                    m_type[uidx][uw]  = int'(update_br_type);
                    m_slot[uidx][uw]  = int'(update_pc[0]);
                    stamp_ctr++;
                    m_stamp[uidx][uw] = stamp_ctr;
                end else if (uh >= 0) begin
                    m_valid[uidx][uh] = 1'b0;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            n_tests++;
            if ({hit, br_target, br_type, pc_2} !== {exp_hit, exp_tgt, exp_type, exp_pc2}) begin
                n_fail++;
                $display("FAIL cycle_cmp t=%0t got hit=%0b tgt=%h type=%0d pc_2=%0b want hit=%0b tgt=%h type=%0d pc_2=%0b",
                         $time, hit, br_target, br_type, pc_2, exp_hit, exp_tgt, exp_type, exp_pc2);
            end
        end
    end

    // Hand-computed expectation: checks both the DUT and the model.
    task automatic check_lit(input string name, input logic h, input logic [29:0] t,
                             input logic [1:0] ty, input logic p);
        n_tests++;
        if ({hit, br_target, br_type, pc_2} !== {h, t, ty, p}) begin
            n_fail++;
            $display("FAIL %s dut got hit=%0b tgt=%h type=%0d pc_2=%0b want hit=%0b tgt=%h type=%0d pc_2=%0b",
                     name, hit, br_target, br_type, pc_2, h, t, ty, p);
        end
        n_tests++;
        if ({exp_hit, exp_tgt, exp_type, exp_pc2} !== {h, t, ty, p}) begin
            n_fail++;
            $display("FAIL %s model got hit=%0b tgt=%h type=%0d pc_2=%0b want hit=%0b tgt=%h type=%0d pc_2=%0b",
                     name, exp_hit, exp_tgt, exp_type, exp_pc2, h, t, ty, p);
        end
    endtask

    task automatic drive(input logic [29:0] lpc, input logic u, input logic [29:0] upc,
                         input logic [1:0] ty, input logic [29:0] tg,
                         input logic fl, input logic rs);
        pc = lpc; update = u; update_pc = upc; update_br_type = ty;
        update_br_target = tg; flush = fl; rst = rs;
        @(negedge clk);
    endtask

    task automatic look(input logic [29:0] lpc);
        drive(lpc, 1'b0, 30'h0, 2'd0, 30'h0, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [29:0] upc, input logic [1:0] ty, input logic [29:0] tg);
        drive(IDLE, 1'b1, upc, ty, tg, 1'b0, 1'b0);
    endtask

    function automatic logic [29:0] mk_pc(input int t, input int s, input int sl);
        return 30'((t << 9) | (s << 1) | sl);
    endfunction

    initial begin
        drive(IDLE, 1'b0, 30'h0, 2'd0, 30'h0, 1'b0, 1'b1);
        drive(IDLE, 1'b0, 30'h0, 2'd0, 30'h0, 1'b0, 1'b1);
        check_lit("post_reset_zero", 1'b0, 30'h0, 2'd0, 1'b0);

        // Lookup right after reset misses
        look(30'h1234);
        check_lit("reset_lookup_miss", 1'b0, 30'h0, 2'd0, 1'b0);

        // Slot bit comes from the stored entry, not the lookup PC
        wr(30'h101, 2'd1, 30'h2000);
        look(30'h100);
        check_lit("stored_slot_hit", 1'b1, 30'h2000, 2'd1, 1'b1);

        // Set 0x80: retarget A, allocate B, touch A, allocate C -> B evicted
        wr(30'h100, 2'd2, 30'h3000);
        wr(30'h300, 2'd1, 30'h3300);
        look(30'h100);
        check_lit("retarget_A", 1'b1, 30'h3000, 2'd2, 1'b0);
        look(IDLE);
        wr(30'h500, 2'd3, 30'h5000);
        look(30'h100);
        check_lit("plru_keep_A", 1'b1, 30'h3000, 2'd2, 1'b0);
        look(30'h500);
        check_lit("plru_alloc_C", 1'b1, 30'h5000, 2'd3, 1'b0);
        look(30'h300);
        check_lit("plru_evict_B", 1'b0, 30'h0, 2'd0, 1'b0);

        // Read-before-write on the same PC
        drive(30'h20, 1'b1, 30'h20, 2'd1, 30'h123, 1'b0, 1'b0);
        check_lit("rbw_same_cycle_miss", 1'b0, 30'h0, 2'd0, 1'b0);
        look(30'h20);
        check_lit("rbw_next_cycle_hit", 1'b1, 30'h123, 2'd1, 1'b0);

        // Second entry in set 0x10, then flush with a dropped update
        wr(30'h221, 2'd2, 30'h221);
        look(30'h221);
        check_lit("set10_way1", 1'b1, 30'h221, 2'd2, 1'b1);
        drive(30'h100, 1'b1, 30'h900, 2'd1, 30'h999, 1'b1, 1'b0);
        check_lit("flush_cycle_miss", 1'b0, 30'h0, 2'd0, 1'b0);
        look(30'h100); check_lit("flush_A", 1'b0, 30'h0, 2'd0, 1'b0);
        look(30'h500); check_lit("flush_C", 1'b0, 30'h0, 2'd0, 1'b0);
        look(30'h20);  check_lit("flush_s10_w0", 1'b0, 30'h0, 2'd0, 1'b0);
        look(30'h221); check_lit("flush_s10_w1", 1'b0, 30'h0, 2'd0, 1'b0);
        look(30'h900); check_lit("flush_drops_update", 1'b0, 30'h0, 2'd0, 1'b0);

        // Re-insert, invalidate, then two allocations fit in the freed set
        wr(30'h100, 2'd1, 30'h4444);
        look(30'h100); check_lit("reinsert_A", 1'b1, 30'h4444, 2'd1, 1'b0);
        wr(30'h100, 2'd0, 30'h0);
        look(30'h100); check_lit("invalidate_A", 1'b0, 30'h0, 2'd0, 1'b0);
        wr(30'h700, 2'd1, 30'h7777);
        wr(30'h300, 2'd2, 30'h3333);
        look(30'h700); check_lit("alloc_after_inv_D", 1'b1, 30'h7777, 2'd1, 1'b0);
        look(30'h300); check_lit("alloc_after_inv_B", 1'b1, 30'h3333, 2'd2, 1'b0);

        // Reset mid-operation with a concurrent update
        drive(30'h700, 1'b1, 30'h20, 2'd1, 30'h77, 1'b0, 1'b1);
        check_lit("rst_outputs_zero", 1'b0, 30'h0, 2'd0, 1'b0);
        look(30'h700); check_lit("rst_lost_D", 1'b0, 30'h0, 2'd0, 1'b0);
        look(30'h300); check_lit("rst_lost_B", 1'b0, 30'h0, 2'd0, 1'b0);
        look(30'h20);  check_lit("rst_drops_update", 1'b0, 30'h0, 2'd0, 1'b0);

        // Last set and set 0 are independent
        wr(30'h1FE, 2'd1, 30'hAAA);
        look(30'h0);   check_lit("wrap_set0_miss", 1'b0, 30'h0, 2'd0, 1'b0);
        look(30'h1FE); check_lit("wrap_setFF_hit", 1'b1, 30'hAAA, 2'd1, 1'b0);
        wr(30'h1, 2'd2, 30'hBBB);
        look(30'h0);   check_lit("wrap_set0_hit", 1'b1, 30'hBBB, 2'd2, 1'b1);
        look(30'h1FF); check_lit("wrap_setFF_kept", 1'b1, 30'hAAA, 2'd1, 1'b0);

        // Mixed traffic on two sets with three tags, checked by the model
        for (int i = 0; i < 400; i++) begin
            drive(mk_pc($urandom_range(0, 2), $urandom_range(128, 129), $urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  mk_pc($urandom_range(0, 2), $urandom_range(128, 129), $urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 30'($urandom()),
                  1'($urandom_range(0, 39) == 0), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
